// File: rtl/comb_logic_pipe_if.sv
// Bus for comb_logic_pipe: control, input sample, and output/status.
// Width of occupancy is derived from the same STAGES/REG_EVERY as the pipe.
interface comb_logic_pipe_if #(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 60,
  parameter int REG_EVERY = 15
);
  localparam int L     = (STAGES + REG_EVERY - 1) / REG_EVERY;
  localparam int OCC_W = $clog2(L + 1);

  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] pm_in;
  logic [WIDTH-1:0] pm_out;
  logic             out_valid;
  logic [OCC_W-1:0] occupancy;
  logic             busy;

  modport master (
    output en, flush, in_valid, pm_in,
    input  pm_out, out_valid, occupancy, busy
  );

  modport slave (
    input  en, flush, in_valid, pm_in,
    output pm_out, out_valid, occupancy, busy
  );
endinterface

// File: rtl/comb_logic_pipe.sv
// Identity AND-chain (x & x per stage) with a register rank every REG_EVERY stages; latency L enabled cycles.
// No ready: en=0 stalls every rank and ignores the input, so upstream must hold its sample.
module comb_logic_pipe #(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 60,
  parameter int REG_EVERY = 15
) (
  input logic              clk,
  input logic              reset_n,
  comb_logic_pipe_if.slave bus
);
  localparam int L     = (STAGES + REG_EVERY - 1) / REG_EVERY;
  localparam int OCC_W = $clog2(L + 1);

  // Stage index feeding rank r; the last rank always taps the chain end.
  function automatic int tap(input int r);
    return (r * REG_EVERY < STAGES) ? r * REG_EVERY : STAGES;
  endfunction

  (* keep = "true" *) logic [WIDTH-1:0] inter [0:STAGES];
  logic [WIDTH-1:0] rank_q [1:L];
  logic [L:1]       vld;
  logic [OCC_W-1:0] occ;
  logic             advance;

  assign inter[0] = bus.pm_in;
  assign advance  = bus.en & ~bus.flush;

  // After each rank the chain restarts from that rank's register output.
  for (genvar k = 1; k <= STAGES; k++) begin : g_chain
    if (k > 1 && ((k - 1) % REG_EVERY) == 0) begin : g_resume
      assign inter[k] = rank_q[(k - 1) / REG_EVERY] & rank_q[(k - 1) / REG_EVERY];
    end else begin : g_link
      assign inter[k] = inter[k - 1] & inter[k - 1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 1; r <= L; r++) rank_q[r] <= '0;
    end else if (advance) begin
      for (int r = 1; r <= L; r++) rank_q[r] <= inter[tap(r)];
    end
  end

  // Occupancy tracks the valid bits incrementally; flush beats en and in_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      occ <= '0;
    end else if (bus.flush) begin
      vld <= '0;
      occ <= '0;
    end else if (bus.en) begin
      vld[1] <= bus.in_valid;
      for (int r = 2; r <= L; r++) vld[r] <= vld[r - 1];
      if (bus.in_valid && !vld[L]) begin
        occ <= occ + OCC_W'(1);
      end else if (!bus.in_valid && vld[L]) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

  assign bus.pm_out    = rank_q[L];
  assign bus.out_valid = vld[L];
  assign bus.occupancy = occ;
  assign bus.busy      = |occ;
endmodule

// File: tb/tb_comb_logic_pipe.sv
// Directed vectors on the default pipe (L=4) plus a randomised stream on a 10/4/16 pipe (L=3).
module tb_comb_logic_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  comb_logic_pipe_if #(.WIDTH(8),  .STAGES(60), .REG_EVERY(15)) a ();
  comb_logic_pipe_if #(.WIDTH(16), .STAGES(10), .REG_EVERY(4))  b ();

  comb_logic_pipe #(.WIDTH(8),  .STAGES(60), .REG_EVERY(15)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a));
  comb_logic_pipe #(.WIDTH(16), .STAGES(10), .REG_EVERY(4))  dut_b (.clk(clk), .reset_n(reset_n), .bus(b));

  typedef struct {
    logic       en;
    logic       flush;
    logic       in_valid;
    logic [7:0] din;
    logic       exp_v;
    logic [7:0] exp_d;
    int         exp_occ;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic en, input logic fl, input logic iv,
                         input logic [7:0] d, input logic ev, input logic [7:0] ed, input int eo);
    vecs[i].en = en; vecs[i].flush = fl; vecs[i].in_valid = iv; vecs[i].din = d;
    vecs[i].exp_v = ev; vecs[i].exp_d = ed; vecs[i].exp_occ = eo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic       mv [3];
    logic [15:0] md [3];
    logic       ren, rfl, riv;
    logic [15:0] rd;
    int         mocc;

    // Single 0xA5 sample, then a stream with a 3-cycle stall in the middle.
    set_vec(0,  1, 0, 1, 8'hA5, 0, 8'h00, 1);
    set_vec(1,  1, 0, 0, 8'h00, 0, 8'h00, 1);
    set_vec(2,  1, 0, 0, 8'h00, 0, 8'h00, 1);
    set_vec(3,  1, 0, 0, 8'h00, 1, 8'hA5, 1);
    set_vec(4,  1, 0, 0, 8'h00, 0, 8'h00, 0);
    set_vec(5,  1, 0, 1, 8'h10, 0, 8'h00, 1);
    set_vec(6,  1, 0, 1, 8'h11, 0, 8'h00, 2);
    set_vec(7,  1, 0, 1, 8'h12, 0, 8'h00, 3);
    set_vec(8,  1, 0, 1, 8'h13, 1, 8'h10, 4);
    set_vec(9,  0, 0, 1, 8'h14, 1, 8'h10, 4);
    set_vec(10, 0, 0, 1, 8'h14, 1, 8'h10, 4);
    set_vec(11, 0, 0, 1, 8'h14, 1, 8'h10, 4);
    set_vec(12, 1, 0, 1, 8'h14, 1, 8'h11, 4);
    set_vec(13, 1, 0, 0, 8'h00, 1, 8'h12, 3);
    set_vec(14, 1, 0, 0, 8'h00, 1, 8'h13, 2);
    set_vec(15, 1, 0, 0, 8'h00, 1, 8'h14, 1);
    set_vec(16, 1, 0, 0, 8'h00, 0, 8'h00, 0);

    a.en = 1'b1; a.flush = 1'b0; a.in_valid = 1'b0; a.pm_in = '0;
    b.en = 1'b1; b.flush = 1'b0; b.in_valid = 1'b0; b.pm_in = '0;

    #2;
    chk("rst_pm_out",    a.pm_out,    0);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_occupancy", a.occupancy, 0);
    chk("rst_busy",      a.busy,      0);
    #6 reset_n = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      a.en = vecs[i].en; a.flush = vecs[i].flush;
      a.in_valid = vecs[i].in_valid; a.pm_in = vecs[i].din;
      step();
      chk($sformatf("vec%0d_valid", i), a.out_valid, vecs[i].exp_v);
      if (vecs[i].exp_v) chk($sformatf("vec%0d_data", i), a.pm_out, vecs[i].exp_d);
      chk($sformatf("vec%0d_occ", i), a.occupancy, vecs[i].exp_occ);
      chk($sformatf("vec%0d_busy", i), a.busy, (vecs[i].exp_occ != 0) ? 1 : 0);
    end

    // Back-to-back stream 0x00..0x0F.
    a.en = 1'b1; a.flush = 1'b0;
    for (int k = 0; k < 20; k++) begin
      int eocc;
      a.in_valid = (k < 16);
      a.pm_in = 8'(k);
      step();
      eocc = 0;
      for (int j = 0; j < 16; j++) if (j <= k && k <= j + 3) eocc++;
      chk($sformatf("stream%0d_valid", k), a.out_valid, (k >= 3 && k <= 18) ? 1 : 0);
      if (k >= 3 && k <= 18) chk($sformatf("stream%0d_data", k), a.pm_out, k - 3);
      chk($sformatf("stream%0d_occ", k), a.occupancy, eocc);
    end

    // Full pipe flushed while a new sample is offered.
    for (int i = 0; i < 4; i++) begin
      a.in_valid = 1'b1; a.pm_in = 8'h40 + 8'(i);
      step();
    end
    chk("full_occ", a.occupancy, 4);
    a.flush = 1'b1; a.in_valid = 1'b1; a.pm_in = 8'h3C;
    step();
    chk("flush_occ",   a.occupancy, 0);
    chk("flush_valid", a.out_valid, 0);
    chk("flush_busy",  a.busy,      0);
    a.flush = 1'b0; a.in_valid = 1'b0; a.pm_in = 8'h00;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post_flush%0d_valid", i), a.out_valid, 0);
    end

    // Asynchronous reset pulse between edges with samples in flight.
    for (int i = 0; i < 4; i++) begin
      a.in_valid = 1'b1; a.pm_in = 8'h21 + 8'(i);
      step();
    end
    a.in_valid = 1'b0; a.pm_in = 8'h00;
    chk("pre_rst_valid", a.out_valid, 1);
    chk("pre_rst_data",  a.pm_out,    8'h21);
    #2 reset_n = 1'b0;
    #2;
    chk("arst_pm_out",    a.pm_out,    0);
    chk("arst_out_valid", a.out_valid, 0);
    chk("arst_occupancy", a.occupancy, 0);
    chk("arst_busy",      a.busy,      0);
    #3 reset_n = 1'b1;
    a.in_valid = 1'b1; a.pm_in = 8'h5A;
    step();
    chk("post_rst_occ", a.occupancy, 1);
    a.in_valid = 1'b0; a.pm_in = 8'h00;
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("post_rst%0d_valid", i), a.out_valid, (i == 3) ? 1 : 0);
    end
    chk("post_rst_data", a.pm_out, 8'h5A);

    // Short pipe: L=3 with an uneven last segment.
    b.in_valid = 1'b1; b.pm_in = 16'hBEEF;
    step();
    b.in_valid = 1'b0; b.pm_in = 16'h0000;
    step();
    chk("b_early_valid", b.out_valid, 0);
    step();
    chk("b_beef_valid", b.out_valid, 1);
    chk("b_beef_data",  b.pm_out,    16'hBEEF);
    chk("b_beef_occ",   b.occupancy, 1);
    step();
    chk("b_drain_valid", b.out_valid, 0);
    chk("b_drain_occ",   b.occupancy, 0);

    for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; md[i] = 16'h0; end
    for (int n = 0; n < 1000; n++) begin
      ren = ($urandom_range(0, 7) != 0);
      rfl = ($urandom_range(0, 49) == 0);
      riv = $urandom_range(0, 1) != 0;
      rd  = 16'($urandom);
      b.en = ren; b.flush = rfl; b.in_valid = riv; b.pm_in = rd;
      if (rfl) begin
        for (int i = 0; i < 3; i++) mv[i] = 1'b0;
      end else if (ren) begin
        mv[2] = mv[1]; md[2] = md[1];
        mv[1] = mv[0]; md[1] = md[0];
        mv[0] = riv;   md[0] = rd;
      end
      step();
      mocc = int'(mv[0]) + int'(mv[1]) + int'(mv[2]);
      chk($sformatf("rand%0d_valid", n), b.out_valid, mv[2]);
      if (mv[2]) chk($sformatf("rand%0d_data", n), b.pm_out, md[2]);
      chk($sformatf("rand%0d_occ", n), b.occupancy, mocc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
